// File: rtl/mod_exp_ctrl_if.sv
// Multiplier request/response bus between the exponentiation controller and a modular multiplier.
interface mod_exp_ctrl_if #(
    parameter int W = 64
);
    logic         mul_start;
    logic [W-1:0] mul_a;
    logic [W-1:0] mul_b;
    logic [W-1:0] mul_n;
    logic         mul_done;
    logic [W-1:0] mul_p;

    modport master (
        output mul_start, mul_a, mul_b, mul_n,
        input  mul_done, mul_p
    );

    modport slave (
        input  mul_start, mul_a, mul_b, mul_n,
        output mul_done, mul_p
    );
endinterface

// File: rtl/mod_exp_ctrl.sv
// Left-to-right square-and-multiply controller computing base^exp mod modulus
// by sequencing an external modular multiplier over a start/done handshake.
module mod_exp_ctrl #(
    parameter int W = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [W-1:0]  base,
    input  logic [W-1:0]  exp,
    input  logic [31:0]   length,
    input  logic [W-1:0]  modulus,
    output logic          busy,
    output logic          done,
    output logic [W-1:0]  result,
    mod_exp_ctrl_if.master mul
);
    localparam int IW = $clog2(W);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE_SQ,
        WAIT_SQ,
        ISSUE_MUL,
        WAIT_MUL,
        FINISH
    } state_t;

    state_t       state;
    logic [W-1:0] base_q;
    logic [W-1:0] exp_q;
    logic [31:0]  idx;
    logic         last_bit;

    assign last_bit = (idx == '0);

    // The accumulator lives in mul_a: every op is launched on the edge that
    // captures the previous product, so mul_a always holds the current acc.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            result        <= '0;
            mul.mul_start <= 1'b0;
            mul.mul_a     <= '0;
            mul.mul_b     <= '0;
            mul.mul_n     <= '0;
            base_q        <= '0;
            exp_q         <= '0;
            idx           <= '0;
        end else begin
            done          <= 1'b0;
            mul.mul_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        base_q <= base;
                        exp_q  <= exp;
                        if (length == '1) begin
                            result <= W'(1);
                            done   <= 1'b1;
                            state  <= FINISH;
                        end else if (length == '0) begin
                            result <= base;
                            done   <= 1'b1;
                            state  <= FINISH;
                        end else begin
                            busy          <= 1'b1;
                            idx           <= length - 32'd1;
                            mul.mul_start <= 1'b1;
                            mul.mul_a     <= base;
                            mul.mul_b     <= base;
                            mul.mul_n     <= modulus;
                            state         <= ISSUE_SQ;
                        end
                    end
                end
                ISSUE_SQ:  state <= WAIT_SQ;
                ISSUE_MUL: state <= WAIT_MUL;
                WAIT_SQ: begin
                    if (mul.mul_done) begin
                        if (exp_q[idx[IW-1:0]]) begin
                            mul.mul_start <= 1'b1;
                            mul.mul_a     <= mul.mul_p;
                            mul.mul_b     <= base_q;
                            state         <= ISSUE_MUL;
                        end else if (last_bit) begin
                            result <= mul.mul_p;
                            done   <= 1'b1;
                            busy   <= 1'b0;
                            state  <= FINISH;
                        end else begin
                            idx           <= idx - 32'd1;
                            mul.mul_start <= 1'b1;
                            mul.mul_a     <= mul.mul_p;
                            mul.mul_b     <= mul.mul_p;
                            state         <= ISSUE_SQ;
                        end
                    end
                end
                WAIT_MUL: begin
                    if (mul.mul_done) begin
                        if (last_bit) begin
                            result <= mul.mul_p;
                            done   <= 1'b1;
                            busy   <= 1'b0;
                            state  <= FINISH;
                        end else begin
                            idx           <= idx - 32'd1;
                            mul.mul_start <= 1'b1;
                            mul.mul_a     <= mul.mul_p;
                            mul.mul_b     <= mul.mul_p;
                            state         <= ISSUE_SQ;
                        end
                    end
                end
                FINISH:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Self-checking bench for mod_exp_ctrl: random-latency multiplier model plus
// a plain-arithmetic modular exponentiation reference.
module tb_mod_exp_ctrl;
    localparam int W  = 64;
    localparam int W2 = 2 * W;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [W-1:0]  base;
    logic [W-1:0]  exp_v;
    logic [31:0]   length;
    logic [W-1:0]  modulus;
    logic          busy;
    logic          done;
    logic [W-1:0]  result;

    mod_exp_ctrl_if #(.W(W)) mif ();

    mod_exp_ctrl #(.W(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .base    (base),
        .exp     (exp_v),
        .length  (length),
        .modulus (modulus),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .mul     (mif)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int n_mulstart = 0;
    int n_done     = 0;
    int force_lat  = 0;
    bit chk_stable = 1'b1;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] expv);
        n_assert++;
        assert (got === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] mulmod(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [W-1:0] n);
        logic [W2-1:0] t;
        t = (W2'(a) * W2'(b)) % W2'(n);
        return t[W-1:0];
    endfunction

    function automatic logic [W-1:0] ref_modexp(input logic [W-1:0] b, input logic [W-1:0] e,
                                                input logic [W-1:0] n);
        logic [W-1:0] r;
        r = W'(1);
        for (int i = W - 1; i >= 0; i--) begin
            r = mulmod(r, r, n);
            if (e[i]) r = mulmod(r, b, n);
        end
        return r;
    endfunction

    // Multiplier model: captures operands on mul_start, answers after 1-20 cycles.
    logic         pend = 1'b0;
    int           cnt;
    logic [W-1:0] ca, cb, cn, cp;

    always @(negedge clk) begin
        if (mif.mul_done) mif.mul_done = 1'b0;
        if (mif.mul_start) n_mulstart++;
        if (done) n_done++;
        if (pend) begin
            if (chk_stable) begin
                chk("mul_a_stable", mif.mul_a, ca);
                chk("mul_b_stable", mif.mul_b, cb);
                chk("mul_n_stable", mif.mul_n, cn);
            end
            cnt--;
            if (cnt == 0) begin
                mif.mul_done = 1'b1;
                mif.mul_p    = cp;
                pend         = 1'b0;
            end
        end
        if (mif.mul_start) begin
            pend = 1'b1;
            ca   = mif.mul_a;
            cb   = mif.mul_b;
            cn   = mif.mul_n;
            cp   = mulmod(mif.mul_a, mif.mul_b, mif.mul_n);
            cnt  = (force_lat > 0) ? force_lat : int'($urandom_range(1, 20));
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, W'(busy), '0);
        chk({tag, "_done"}, W'(done), '0);
        chk({tag, "_result"}, result, '0);
        chk({tag, "_mul_start"}, W'(mif.mul_start), '0);
        chk({tag, "_mul_a"}, mif.mul_a, '0);
        chk({tag, "_mul_b"}, mif.mul_b, '0);
        chk({tag, "_mul_n"}, mif.mul_n, '0);
    endtask

    task automatic run(input string tag, input logic [W-1:0] b, input logic [W-1:0] e,
                       input logic [W-1:0] n, input bit noisy);
        int           len;
        int           exp_ops;
        int           ms0;
        int           dn0;
        bit           seen;
        logic [W-1:0] expr;
        len = -1;
        for (int i = 0; i < W; i++) if (e[i]) len = i;
        exp_ops = (len > 0) ? len : 0;
        for (int i = 0; i < len; i++) if (e[i]) exp_ops++;
        expr = ref_modexp(b, e, n);
        ms0 = n_mulstart;
        dn0 = n_done;
        base = b; exp_v = e; modulus = n; length = 32'(len); start = 1'b1;
        tick();
        start = 1'b0;
        if (len <= 0) begin
            chk({tag, "_done_t1"}, W'(done), W'(1));
            chk({tag, "_busy_t1"}, W'(busy), '0);
            chk({tag, "_mul_start_t1"}, W'(mif.mul_start), '0);
        end else begin
            chk({tag, "_busy_t1"}, W'(busy), W'(1));
            chk({tag, "_mul_start_t1"}, W'(mif.mul_start), W'(1));
            chk({tag, "_first_a"}, mif.mul_a, b);
            chk({tag, "_first_b"}, mif.mul_b, b);
            chk({tag, "_first_n"}, mif.mul_n, n);
            seen = 1'b0;
            for (int c = 0; c < 20000; c++) begin
                tick();
                if (done === 1'b1) begin
                    seen = 1'b1;
                    break;
                end
                start = noisy && ($urandom_range(0, 3) == 0);
                if (noisy) begin
                    base = {$urandom, $urandom}; exp_v = {$urandom, $urandom};
                    length = $urandom_range(0, 40); modulus = {$urandom, $urandom} | W'(2);
                end
            end
            chk({tag, "_done_seen"}, W'(seen), W'(1));
            chk({tag, "_busy_at_done"}, W'(busy), '0);
        end
        chk({tag, "_result"}, result, expr);
        start = noisy;
        if (noisy) begin
            base = W'(3); exp_v = W'(5); length = 32'd2; modulus = W'(7);
        end
        tick();
        start = 1'b0;
        chk({tag, "_done_pulse"}, W'(done), '0);
        chk({tag, "_busy_after"}, W'(busy), '0);
        chk({tag, "_no_restart"}, W'(mif.mul_start), '0);
        chk({tag, "_result_hold"}, result, expr);
        tick();
        chk({tag, "_mul_ops"}, W'(n_mulstart - ms0), W'(exp_ops));
        chk({tag, "_done_count"}, W'(n_done - dn0), W'(1));
    endtask

    initial begin
        logic [W-1:0] rb, re, rn;
        int           rlen;
        int           ms0;
        int           dn0;
        bit           seen;
        bit           bad;

        rst = 1'b1; start = 1'b0; base = '0; exp_v = '0; length = '0; modulus = '0;
        mif.mul_done = 1'b0; mif.mul_p = '0;
        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        run("e13", W'(4), W'(13), W'(497), 1'b0);
        chk("e13_known_value", result, W'(445));
        run("e0", W'(7), W'(0), W'(11), 1'b0);
        run("e1", W'(9), W'(1), W'(23), 1'b1);
        run("f4", W'(2), W'(65537), W'(1000003), 1'b0);

        for (int k = 0; k < 6; k++) begin
            rn = {$urandom, $urandom};
            if (rn < W'(2)) rn = W'(2);
            rb = {$urandom, $urandom} % rn;
            rlen = $urandom_range(1, 63);
            re = {$urandom, $urandom} >> (63 - rlen);
            re[rlen] = 1'b1;
            run("rand", rb, re, rn, k[0]);
        end

        // Abort a run in WAIT_MUL; its late mul_done must land harmlessly in IDLE.
        force_lat = 4;
        base = W'(4); exp_v = W'(13); length = 32'd3; modulus = W'(497); start = 1'b1;
        tick();
        start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 200; c++) begin
            tick();
            start = (c == 1);
            base = (c == 1) ? W'(99) : W'(4);
            if (n_mulstart >= 2 + 0 && c > 1) begin
                start = 1'b0;
                seen = 1'b1;
                break;
            end
        end
        chk("abort_reach_mul", W'(seen), W'(1));
        chk("abort_busy", W'(busy), W'(1));
        chk("abort_latched_base", mif.mul_b, W'(4));
        chk("abort_waiting", W'(mif.mul_start), '0);
        chk_stable = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_outputs("abort");
        ms0 = n_mulstart;
        dn0 = n_done;
        bad = 1'b0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (mif.mul_start !== 1'b0 || done !== 1'b0 || busy !== 1'b0) bad = 1'b1;
        end
        chk("abort_quiet", W'(bad), '0);
        chk("abort_no_mul", W'(n_mulstart - ms0), '0);
        chk("abort_no_done", W'(n_done - dn0), '0);
        force_lat = 0;
        chk_stable = 1'b1;

        run("e13_after_abort", W'(4), W'(13), W'(497), 1'b1);
        chk("e13_after_abort_value", result, W'(445));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
